// File: rtl/store_checker_pkg.sv
// Shared types and default constants for the store checker slice.
package store_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_N           = 10;
  localparam int DEF_MODE        = 0;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Table index width; a one-entry table still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_strobe_det.sv
// Rising-edge detector on CS&WE: one strobe per write, however long WE is held.
module store_strobe_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_i,
  input  logic we_i,
  output logic strobe_o
);

  logic sel;
  logic sel_q;

  assign sel = cs_i & we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sel_q <= 1'b0;
    else       sel_q <= sel;
  end

  assign strobe_o = sel & ~sel_q;

endmodule

// File: rtl/store_checker.sv
// Compares a run of CPU memory stores against a preloaded expectation table,
// reporting pass/fail, mismatch count, first mismatch and inactivity timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int N           = DEF_N,
  parameter int MODE        = DEF_MODE,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      exp_we,
  input  logic [idx_w(N)-1:0]       exp_idx,
  input  logic [DATA_W-1:0]         exp_data,
  input  logic [ADDR_W-1:0]         exp_addr,
  input  logic                      CS,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         Address,
  input  logic [DATA_W-1:0]         Mem_Bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [$clog2(N+1)-1:0]    chk_idx,
  output logic [$clog2(N+1)-1:0]    err_cnt,
  output logic                      err_pulse,
  output logic [idx_w(N)-1:0]       first_err_idx,
  output logic [DATA_W-1:0]         first_err_data
);

  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int TIM_W = $clog2(TIMEOUT_CYC);

  state_e            state_q;
  logic [DATA_W-1:0] dtab_q [N];
  logic [ADDR_W-1:0] atab_q [N];
  logic [CNT_W-1:0]  chk_idx_q, chk_idx_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [TIM_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  ferr_idx_q;
  logic [DATA_W-1:0] ferr_data_q;
  logic              timeout_q;
  logic              err_pulse_q;

  logic              strobe;
  logic [IDX_W-1:0]  cur_idx;
  logic              mismatch;
  logic              last_store;
  logic              timer_end;
  logic              tab_wr;

  store_strobe_det u_strobe (
    .clk_i    (CLK),
    .rst_i    (rst),
    .cs_i     (CS),
    .we_i     (WE),
    .strobe_o (strobe)
  );

  assign cur_idx    = chk_idx_q[IDX_W-1:0];
  assign mismatch   = (Mem_Bus != dtab_q[cur_idx]) |
                      ((MODE != 0) & (Address != atab_q[cur_idx]));
  assign last_store = (chk_idx_q == CNT_W'(N - 1));
  assign timer_end  = (timer_q == TIM_W'(TIMEOUT_CYC - 1));
  assign chk_idx_d  = chk_idx_q + CNT_W'(1);
  assign err_cnt_d  = err_cnt_q + CNT_W'(1);
  assign timer_d    = timer_q + TIM_W'(1);

  // The table is frozen while a run is in progress so compares stay stable.
  assign tab_wr = exp_we & (state_q != ST_RUN) & (32'(exp_idx) < N);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        dtab_q[i] <= '0;
        atab_q[i] <= '0;
      end
    end else if (tab_wr) begin
      dtab_q[exp_idx] <= exp_data;
      atab_q[exp_idx] <= exp_addr;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      chk_idx_q   <= '0;
      err_cnt_q   <= '0;
      timer_q     <= '0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
      timeout_q   <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // Strobes here only feed the edge history; start opens a fresh run.
          if (start) begin
            state_q     <= ST_RUN;
            chk_idx_q   <= '0;
            err_cnt_q   <= '0;
            timer_q     <= '0;
            ferr_idx_q  <= '0;
            ferr_data_q <= '0;
            timeout_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (strobe) begin
            timer_q   <= '0;
            chk_idx_q <= chk_idx_d;
            if (mismatch) begin
              err_cnt_q   <= err_cnt_d;
              err_pulse_q <= 1'b1;
              if (err_cnt_q == '0) begin
                ferr_idx_q  <= cur_idx;
                ferr_data_q <= Mem_Bus;
              end
            end
            if (last_store) state_q <= ST_DONE;
          end else if (timer_end) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = done & ~timeout_q & (err_cnt_q == '0);
  assign timeout        = timeout_q;
  assign chk_idx        = chk_idx_q;
  assign err_cnt        = err_cnt_q;
  assign err_pulse      = err_pulse_q;
  assign first_err_idx  = ferr_idx_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Drives a data-only and a data+address checker with the same stimulus and
// compares every cycle against a store-level reference model.
module tb_store_checker;

  localparam int N  = 10;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, exp_we = 1'b0, CS = 1'b0, WE = 1'b0;
  logic [IW-1:0] exp_idx = '0;
  logic [DW-1:0] exp_data = '0, Mem_Bus = '0;
  logic [AW-1:0] exp_addr = '0, Address = '0;

  logic [1:0]    busy, done, pass, timeout, err_pulse;
  logic [CW-1:0] chk_idx [2];
  logic [CW-1:0] err_cnt [2];
  logic [IW-1:0] first_err_idx [2];
  logic [DW-1:0] first_err_data [2];

  always #5 CLK = ~CLK;

  store_checker #(.DATA_W(DW), .ADDR_W(AW), .N(N), .MODE(0), .TIMEOUT_CYC(TO)) dut0 (
    .CLK(CLK), .rst(rst), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_data(exp_data), .exp_addr(exp_addr), .CS(CS), .WE(WE), .Address(Address),
    .Mem_Bus(Mem_Bus), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .timeout(timeout[0]), .chk_idx(chk_idx[0]), .err_cnt(err_cnt[0]),
    .err_pulse(err_pulse[0]), .first_err_idx(first_err_idx[0]),
    .first_err_data(first_err_data[0]));

  store_checker #(.DATA_W(DW), .ADDR_W(AW), .N(N), .MODE(1), .TIMEOUT_CYC(TO)) dut1 (
    .CLK(CLK), .rst(rst), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_data(exp_data), .exp_addr(exp_addr), .CS(CS), .WE(WE), .Address(Address),
    .Mem_Bus(Mem_Bus), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .timeout(timeout[1]), .chk_idx(chk_idx[1]), .err_cnt(err_cnt[1]),
    .err_pulse(err_pulse[1]), .first_err_idx(first_err_idx[1]),
    .first_err_data(first_err_data[1]));

  // Reference model: one record per instance, updated once per rising edge.
  int            m_st [2], m_cnt [2], m_err [2], m_fidx [2], m_idle [2];
  bit            m_to [2], m_pulse [2];
  logic [DW-1:0] m_fdata [2];
  logic [DW-1:0] m_dtab [2][N];
  logic [AW-1:0] m_atab [2][N];
  bit            m_prev;

  int n_cmp = 0, n_bad = 0, pulses = 0;

  logic [DW-1:0] vals [N] = '{32'h6, 32'h12, 32'h18, 32'hC, 32'h2, 32'h16,
                              32'h1, 32'h120, 32'h3, 32'h00412022};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_cnt[i] = 0; m_err[i] = 0; m_fidx[i] = 0; m_idle[i] = 0;
      m_to[i] = 1'b0; m_pulse[i] = 1'b0; m_fdata[i] = '0;
      for (int j = 0; j < N; j++) begin
        m_dtab[i][j] = '0;
        m_atab[i][j] = '0;
      end
    end
  endfunction

  function automatic void model_edge();
    bit sel, stb, bad;
    sel = CS & WE;
    stb = sel && !m_prev;
    m_prev = sel;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      if (m_st[i] != S_RUN) begin
        if (exp_we && int'(exp_idx) < N) begin
          m_dtab[i][exp_idx] = exp_data;
          m_atab[i][exp_idx] = exp_addr;
        end
        if (start) begin
          m_st[i] = S_RUN; m_cnt[i] = 0; m_err[i] = 0; m_fidx[i] = 0;
          m_fdata[i] = '0; m_to[i] = 1'b0; m_idle[i] = 0;
        end
      end else if (stb) begin
        bad = (Mem_Bus != m_dtab[i][m_cnt[i]]) ||
              (i == 1 && Address != m_atab[i][m_cnt[i]]);
        if (bad) begin
          if (m_err[i] == 0) begin
            m_fidx[i]  = m_cnt[i];
            m_fdata[i] = Mem_Bus;
          end
          m_err[i]++;
          m_pulse[i] = 1'b1;
        end
        m_cnt[i]++;
        m_idle[i] = 0;
        if (m_cnt[i] == N) m_st[i] = S_DONE;
      end else begin
        // TO consecutive edges with no store end the run.
        m_idle[i]++;
        if (m_idle[i] == TO) begin
          m_st[i] = S_DONE;
          m_to[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), busy[i], m_st[i] == S_RUN);
      chk($sformatf("done%0d", i), done[i], m_st[i] == S_DONE);
      chk($sformatf("pass%0d", i), pass[i], m_st[i] == S_DONE && !m_to[i] && m_err[i] == 0);
      chk($sformatf("timeout%0d", i), timeout[i], m_to[i]);
      chk($sformatf("chk_idx%0d", i), 64'(chk_idx[i]), 64'(m_cnt[i]));
      chk($sformatf("err_cnt%0d", i), 64'(err_cnt[i]), 64'(m_err[i]));
      chk($sformatf("err_pulse%0d", i), err_pulse[i], m_pulse[i]);
      chk($sformatf("first_err_idx%0d", i), 64'(first_err_idx[i]), 64'(m_fidx[i]));
      chk($sformatf("first_err_data%0d", i), 64'(first_err_data[i]), 64'(m_fdata[i]));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
    if (err_pulse[0]) pulses++;
  endtask

  task automatic quiet();
    start = 1'b0; exp_we = 1'b0; CS = 1'b0; WE = 1'b0;
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h1000 + 4 * i);
  endfunction

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      exp_we = 1'b1; exp_idx = IW'(i); exp_data = vals[i]; exp_addr = addr_of(i);
      tick();
    end
    exp_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input int hold, input int gap);
    CS = 1'b1; WE = 1'b1; Mem_Bus = d; Address = a;
    repeat (hold) tick();
    CS = 1'b0; WE = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (!done[0] && k < max) begin
      tick();
      k++;
    end
    chk(tag, done[0], 1'b1);
  endtask

  task automatic async_reset();
    quiet();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst.busy", busy, 2'b00);
    chk("rst.chk_idx", 64'(chk_idx[0]), 64'd0);
    @(negedge CLK) rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int qcnt;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1 check_all();
    @(negedge CLK) rst = 1'b0;

    // Ten matching stores
    load_table();
    do_start();
    for (int i = 0; i < N; i++) store(vals[i], addr_of(i), 1, 1 + (i % 3));
    wait_done("s1.done", 5);
    chk("s1.pass0", pass[0], 1'b1);
    chk("s1.pass1", pass[1], 1'b1);
    chk("s1.chk_idx", 64'(chk_idx[0]), 64'd10);

    // Store 4 carries a bad value
    pulses = 0;
    do_start();
    for (int i = 0; i < N; i++) store((i == 3) ? 32'h0D : vals[i], addr_of(i), 1, 1);
    wait_done("s2.done", 5);
    chk("s2.pulses", 64'(pulses), 64'd1);
    chk("s2.err_cnt", 64'(err_cnt[0]), 64'd1);
    chk("s2.first_err_idx", 64'(first_err_idx[0]), 64'd3);
    chk("s2.first_err_data", 64'(first_err_data[0]), 64'h0D);
    chk("s2.pass", pass[0], 1'b0);

    // Long WE hold counts once; WE without CS is not a store
    do_start();
    store(vals[0], addr_of(0), 5, 1);
    chk("s3.hold", 64'(chk_idx[0]), 64'd1);
    WE = 1'b1; Mem_Bus = vals[1]; Address = addr_of(1);
    repeat (3) tick();
    WE = 1'b0;
    tick();
    chk("s3.we_only", 64'(chk_idx[0]), 64'd1);
    for (int i = 1; i < N; i++) store(vals[i], addr_of(i), 2, 1);
    wait_done("s3.done", 5);
    chk("s3.pass", pass[0], 1'b1);

    // Inactivity timeout after three stores
    do_start();
    for (int i = 0; i < 3; i++) store(vals[i], addr_of(i), 1, 1);
    wait_done("s4.done", 3 * TO);
    chk("s4.timeout", timeout[0], 1'b1);
    chk("s4.pass", pass[0], 1'b0);
    chk("s4.chk_idx", 64'(chk_idx[0]), 64'd3);

    // Wrong address on store 2 only matters in address mode
    do_start();
    for (int i = 0; i < N; i++) store(vals[i], addr_of(i) ^ ((i == 1) ? 32'h40 : 32'h0), 1, 1);
    wait_done("s5.done", 5);
    chk("s5.err_cnt1", 64'(err_cnt[1]), 64'd1);
    chk("s5.first_err_idx1", 64'(first_err_idx[1]), 64'd1);
    chk("s5.pass0", pass[0], 1'b1);

    // Reset mid-run, then a clean run
    do_start();
    for (int i = 0; i < 5; i++) store(vals[i], addr_of(i), 1, 1);
    async_reset();
    tick();
    chk("s6.no_done", done, 2'b00);
    load_table();
    do_start();
    for (int i = 0; i < N; i++) store(vals[i], addr_of(i), 1, 1);
    wait_done("s6.done", 5);
    chk("s6.pass", pass, 2'b11);

    // Randomized traffic: table updates, restarts, holds, gaps, timeouts
    qcnt = 0;
    for (int c = 0; c < 2500; c++) begin
      start    = ($urandom % 25 == 0);
      exp_we   = ($urandom % 6 == 0);
      exp_idx  = IW'($urandom % 16);
      exp_data = DW'($urandom % 4);
      exp_addr = AW'($urandom % 4);
      if (qcnt == 0 && $urandom % 150 == 0) qcnt = TO + 4;
      if (qcnt > 0) begin
        CS = 1'b0; WE = 1'b0; qcnt--;
      end else begin
        CS = ($urandom % 3 != 0);
        WE = ($urandom % 2 == 0);
        Mem_Bus = ($urandom % 4 == 0) ? DW'($urandom % 4) : m_dtab[0][m_cnt[0] % N];
        Address = ($urandom % 5 == 0) ? AW'($urandom % 4) : m_atab[1][m_cnt[1] % N];
      end
      tick();
    end
    quiet();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter DATA_W, default 32: width of data bus and expected data entries.
REQ-002 Parameter ADDR_W, default 32: width of address bus and expected address entries.
REQ-003 Parameter N, default 10: number of expected stores (depth of expectation table), N >= 1.
REQ-004 Parameter MODE, default 0: 0 = check data only, 1 = check data and address.
REQ-005 Parameter TIMEOUT_CYC, default 1024: maximum cycles between stores in RUN, >= 2.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  begin checking run (accepted in IDLE or DONE only).
REQ-009 exp_we  in  1  write strobe for expectation table.
REQ-010 exp_idx  in  clog2(N)  table index for exp_we.
REQ-011 exp_data  in  DATA_W  expected store data.
REQ-012 exp_addr  in  ADDR_W  expected store address (used when MODE=1).
REQ-013 CS  in  1  memory chip select from CPU.
REQ-014 WE  in  1  memory write enable from CPU.
REQ-015 Address  in  ADDR_W  CPU memory address.
REQ-016 Mem_Bus  in  DATA_W  CPU memory data bus.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  high in DONE.
REQ-019 pass  out  1  valid when done: all N compares matched, no timeout.
REQ-020 timeout  out  1  run ended by inactivity.
REQ-021 chk_idx  out  clog2(N+1)  number of stores compared this run.
REQ-022 err_cnt  out  clog2(N+1)  mismatching stores this run.
REQ-023 err_pulse  out  1  one-cycle pulse after a mismatching compare.
REQ-024 first_err_idx  out  clog2(N)  table index of first mismatch.
REQ-025 first_err_data  out  DATA_W  Mem_Bus value captured at first mismatch.

Function
REQ-026 States: IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on Nth compare or timeout; DONE holds until start or rst.
REQ-027 Entering RUN clears chk_idx, err_cnt, timeout, first_err_*, timer.
REQ-028 Store strobe = (CS & WE) sampled high at edge k while sampled low at edge k-1; WE held high multiple cycles counts once.
REQ-029 WE high with CS low is not a store; strobes outside RUN are ignored but still update edge history.
REQ-030 On strobe at edge k in RUN: compare Mem_Bus to table[chk_idx] (and Address to addr table when MODE=1), increment chk_idx at edge k.
REQ-031 Mismatch at edge k: err_cnt increments, err_pulse high for the cycle after edge k; first_err_* loaded only if err_cnt was 0.
REQ-032 If chk_idx was N-1 at strobe, state becomes DONE at edge k (done visible same cycle as err_pulse).
REQ-033 Timer increments each RUN cycle without strobe, clears on strobe; reaching TIMEOUT_CYC-1 moves to DONE with timeout=1.
REQ-034 Strobe and timer terminal in same cycle: strobe wins, no timeout.
REQ-035 pass = done & ~timeout & (err_cnt==0).
REQ-036 exp_we writes table at edge in IDLE/DONE only; ignored in RUN; exp_idx >= N ignored.
REQ-037 start while in RUN ignored; start and strobe same edge in IDLE: strobe ignored.

Reset
REQ-038 rst asynchronously forces IDLE; busy, done, pass, timeout, err_pulse=0; chk_idx, err_cnt, first_err_*=0; edge history=0; table entries=0.
REQ-039 rst mid-run abandons the run; no done is produced.

Structure
REQ-040 Shared package holds state enum (IDLE/RUN/DONE) and default parameter constants.
REQ-041 One sub-module, store_strobe_det: registered CS&WE rising-edge detector.

Verification
REQ-042 Load 10 entries (6,0x12,0x18,0xC,2,0x16,1,0x120,3,0x00412022), start, drive 10 matching stores -> done=1, pass=1, err_cnt=0, chk_idx=10.
REQ-043 Same, store 4 drives 0x0D -> one err_pulse, err_cnt=1, first_err_idx=3, first_err_data=0x0D, pass=0.
REQ-044 WE held high 5 cycles with CS=1 -> chk_idx increments by 1; WE=1 with CS=0 -> no change.
REQ-045 TIMEOUT_CYC=16, 3 stores then idle -> DONE with timeout=1, pass=0, chk_idx=3.
REQ-046 MODE=1, correct data but wrong Address on store 2 -> err_cnt=1, first_err_idx=1.
REQ-047 rst asserted after 5 stores -> outputs zero immediately; new start and 10 matching stores -> pass=1.
